uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised successor to the single-buffer UART transmitter, for the memory-mapped IO bus.
- Characters are queued in a FIFO rather than one holding register.
- Frame format is run-time configurable: data bits, parity and stop-bit count.
- Back-to-back frames are sent with no idle gap between them.
- Driven by the shared baud-rate generator's one-cycle bit tick (brg_full); txd goes to the pad.

Parameters:
- DATA_W, 8, character width in bits (5..8); only databus[DATA_W-1:0] is transmitted.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived; do not override).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- brg_full  input  1  bit-period tick from the baud generator, high for one clk per bit time.
- iocs  input  1  chip select.
- iorw  input  1  1 = read, 0 = write; this block acts only on writes.
- ioaddr  input  2  register select: 0 = TX data, 1 = config, 2 = clear overflow, 3 = reserved (ignored).
- databus  input  8  write data.
- tbr  output  1  transmit buffer ready; equals ~fifo_full.
- txd  output  1  serial out; idle/mark = 1.
- tx_busy  output  1  high while a frame is in progress (any state other than IDLE).
- fifo_count  output  CNT_W  number of queued characters, 0..FIFO_DEPTH.
- overflow  output  1  sticky flag: a data write was dropped.

Behaviour:
- Write strobe: wr = iocs & ~iorw. All outputs are registered.
- Reset values: txd=1, tbr=1, tx_busy=0, fifo_count=0, overflow=0, config=0 (no parity, even parity selected, 1 stop bit), state=IDLE.
- rst has priority over every other event. A reset mid-frame aborts the frame, returns txd to 1 on the next cycle and flushes the FIFO.
- Config register (wr, ioaddr=1):
  - databus[0] = parity_en.
  - databus[1] = parity_odd.
  - databus[2] = two_stop.
  - Sampled into the frame when the frame starts; a config write mid-frame affects only later frames.
- Push (wr, ioaddr=0):
  - Accepted if fifo_count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the data is dropped and overflow is set.
- Overflow clear (wr, ioaddr=2): clears overflow. A simultaneous set wins; overflow only ever flags dropped writes.
- Pop: occurs on a brg_full cycle while the FIFO is non-empty and the FSM is in IDLE or on its final STOP bit. The head is loaded into the shift register.
- Same-cycle push and pop: fifo_count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- FSM: advances only on brg_full cycles; txd is updated the cycle after the tick. States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: txd=1. On brg_full with FIFO non-empty: pop, go to START, txd=0.
  - START: on brg_full, go to DATA; txd = bit0 (LSB first).
  - DATA:
    - Bit counter runs 0..DATA_W-1; each brg_full sends the next bit.
    - After bit DATA_W-1: go to PARITY if parity_en, else to STOP.
    - Parity bit = XOR of the data bits, inverted when parity_odd.
  - PARITY: on brg_full, go to STOP; txd=1.
  - STOP:
    - Holds 1 bit time, or 2 when two_stop (stop counter).
    - On brg_full at the end of the last stop bit: if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Frame length in brg_full ticks: 1 + DATA_W + parity_en + (1 + two_stop).
- Latency: a write at cycle N makes fifo_count=1 at N+1. The first brg_full at cycle M >= N+1 drives txd=0 at M+1.
- brg_full during the write cycle itself does not pop the character being written.

Decomposition:
- Shared package uart_pkg:
  - State enum tx_state_t (IDLE/START/DATA/PARITY/STOP).
  - ioaddr constants ADDR_DATA=0, ADDR_CFG=1, ADDR_CLR=2.
  - Config bit indices.
- One sub-module: sync_fifo (parameters WIDTH, DEPTH).
  - Ports: push, pop, din, dout (first-word-fall-through), full, empty, count.
  - Reused later by the receiver.

Test Plan:
- Reset, then write 0x55 (config 0, DATA_W=8), brg_full every 16 clk -> txd per tick: 0,1,0,1,0,1,0,1,0,1; tx_busy falls after the stop bit; fifo_count returns to 0.
- Config 0x03 (odd parity), write 0xA3 -> 4 ones, so the parity bit is 1. Frame = 0,1,1,0,0,0,1,0,1,1,1 (11 bits).
- Config 0x04 (two stop bits), write 0x00 and 0xFF back-to-back -> two stop ticks at 1, then the second start bit follows immediately with no extra idle tick; no gap in tx_busy.
- Write 5 characters with FIFO_DEPTH=4 before any tick -> fifo_count=4, tbr=0, overflow=1, 5th character never sent. Write ioaddr=2 -> overflow=0.
- Fill the FIFO, then push on the same cycle as a pop -> push accepted, fifo_count stays 4, overflow stays 0.
- Assert rst during DATA bit 3 -> next cycle txd=1, tx_busy=0, fifo_count=0, tbr=1; a new write afterwards transmits normally.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, register addresses and config bit indices
//
// Contents:
//   tx_state_t            transmitter FSM states
//   ADDR_DATA/CFG/CLR     ioaddr register select codes
//   CFG_PAR_EN/ODD/TWO    bit positions inside the config register
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CFG  = 2'd1;
    localparam logic [1:0] ADDR_CLR  = 2'd2;

    localparam int CFG_PAR_EN   = 0;
    localparam int CFG_PAR_ODD  = 1;
    localparam int CFG_TWO_STOP = 2;
    localparam int CFG_W        = 3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (flushes contents)
//   push, din       write request and data; accepted when not full or when
//                   a pop happens in the same cycle
//   pop, dout       read request and current head (valid while not empty)
//   full, empty     registered status flags
//   count           registered number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_next;

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wr_ptr points, so the push can land there on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == FULL_CNT);
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with run-time frame format
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   brg_full        one-cycle bit tick from the baud generator
//   iocs, iorw      chip select and read(1)/write(0); only writes are used
//   ioaddr, databus register select (0 data, 1 config, 2 clear overflow) and data
//   tbr             transmit buffer ready (FIFO not full)
//   txd             serial output, idle high
//   tx_busy         frame in progress
//   fifo_count      queued characters
//   overflow        sticky flag for dropped data writes
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             brg_full,
    input  logic             iocs,
    input  logic             iorw,
    input  logic [1:0]       ioaddr,
    input  logic [7:0]       databus,
    output logic             tbr,
    output logic             txd,
    output logic             tx_busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic              wr;
    logic              push_req;
    logic              cfg_wr;
    logic              clr_wr;
    logic              pop;
    logic              last_stop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    logic [CFG_W-1:0]  cfg_q;

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              stop_cnt_q, stop_cnt_d;
    logic              par_q, par_d;
    logic              par_en_q, par_en_d;
    logic              two_stop_q, two_stop_d;
    logic              txd_q, txd_d;
    logic              busy_q;

    assign wr       = iocs & ~iorw;
    assign push_req = wr & (ioaddr == ADDR_DATA);
    assign cfg_wr   = wr & (ioaddr == ADDR_CFG);
    assign clr_wr   = wr & (ioaddr == ADDR_CLR);

    // The final stop bit is where the next queued character may start
    // without an idle bit in between.
    assign last_stop = ~two_stop_q | stop_cnt_q;
    assign pop = brg_full & ~fifo_empty &
                 ((state_q == IDLE) | ((state_q == STOP) & last_stop));

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   (databus[DATA_W-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tbr     = ~fifo_full;
    assign txd     = txd_q;
    assign tx_busy = busy_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        txd_d      = txd_q;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (pop) begin
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (brg_full) begin
                    state_d   = DATA;
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (brg_full) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d    = STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (brg_full) begin
                    state_d    = STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (brg_full) begin
                    if (!last_stop) begin
                        stop_cnt_d = 1'b1;
                    end else if (pop) begin
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Frame format is captured at the start bit so later config writes
        // only affect the following frames.
        if (pop) begin
            shreg_d    = fifo_dout;
            par_d      = (^fifo_dout) ^ cfg_q[CFG_PAR_ODD];
            par_en_d   = cfg_q[CFG_PAR_EN];
            two_stop_d = cfg_q[CFG_TWO_STOP];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (cfg_wr) begin
                cfg_q <= databus[CFG_W-1:0];
            end
            // A dropped write in the same cycle as a clear keeps the flag set.
            if (push_req && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_wr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int GAP = 16;

    logic       clk;
    logic       rst;
    logic       brg_full;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus;
    logic       tbr;
    logic       txd;
    logic       tx_busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .brg_full   (brg_full),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .tbr        (tbr),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = a;
        databus = d;
        @(negedge clk);
        iocs    = 1'b0;
        ioaddr  = 2'd0;
        databus = 8'h00;
    endtask

    task automatic tick();
        brg_full = 1'b1;
        @(negedge clk);
        brg_full = 1'b0;
        repeat (GAP - 1) @(negedge clk);
    endtask

    // Collects the 8 data bits after a start tick, then takes the stop tick.
    task automatic rx_body(output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            d[i] = txd;
        end
        tick();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        brg_full = 1'b0;
        iocs     = 1'b0;
        iorw     = 1'b1;
        ioaddr   = 2'd0;
        databus  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
        total++; if (tbr !== 1'b1) begin bad++; $display("FAIL reset_tbr got=%b exp=1", tbr); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_basic();
        bit exp_bits [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        bus_write(2'd1, 8'h00);
        bus_write(2'd0, 8'h55);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", fifo_count); end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL basic_pre_txd got=%b exp=1", txd); end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (txd !== exp_bits[i]) begin bad++; $display("FAIL basic_txd tick=%0d got=%b exp=%b", i + 1, txd, exp_bits[i]); end
            total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL basic_busy tick=%0d got=%b exp=1", i + 1, tx_busy); end
        end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL basic_count0 got=%0d exp=0", fifo_count); end
        tick();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b exp=0", tx_busy); end
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL basic_txd_end got=%b exp=1", txd); end
    endtask

    task automatic test_parity();
        bit exp_bits [11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 1};
        bus_write(2'd1, 8'h03);
        bus_write(2'd0, 8'hA3);
        for (int i = 0; i < 11; i++) begin
            tick();
            total++; if (txd !== exp_bits[i]) begin bad++; $display("FAIL parity_txd tick=%0d got=%b exp=%b", i + 1, txd, exp_bits[i]); end
        end
        tick();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL parity_busy_end got=%b exp=0", tx_busy); end
    endtask

    task automatic test_back_to_back();
        bit exp_bits [22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                              0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        bus_write(2'd1, 8'h04);
        bus_write(2'd0, 8'h00);
        bus_write(2'd0, 8'hFF);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count2 got=%0d exp=2", fifo_count); end
        for (int i = 0; i < 22; i++) begin
            tick();
            total++; if (txd !== exp_bits[i]) begin bad++; $display("FAIL b2b_txd tick=%0d got=%b exp=%b", i + 1, txd, exp_bits[i]); end
            total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy tick=%0d got=%b exp=1", i + 1, tx_busy); end
        end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_count0 got=%0d exp=0", fifo_count); end
        tick();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", tx_busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        bus_write(2'd1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            bus_write(2'd0, 8'h11 + 8'(i));
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
        total++; if (tbr !== 1'b0) begin bad++; $display("FAIL ovf_tbr got=%b exp=0", tbr); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        bus_write(2'd2, 8'h00);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        for (int k = 0; k < 4; k++) begin
            tick();
            rx_body(d);
            total++; if (d !== 8'h11 + 8'(k)) begin bad++; $display("FAIL ovf_char k=%0d got=%02h exp=%02h", k, d, 8'h11 + 8'(k)); end
        end
        tick();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_end got=%b exp=0", tx_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL ovf_count_end got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d;
        bus_write(2'd1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            bus_write(2'd0, 8'h21 + 8'(i));
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL pp_full_count got=%0d exp=4", fifo_count); end
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = 2'd0;
        databus  = 8'h25;
        brg_full = 1'b1;
        @(negedge clk);
        iocs     = 1'b0;
        databus  = 8'h00;
        brg_full = 1'b0;
        repeat (GAP - 1) @(negedge clk);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL pp_count got=%0d exp=4", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL pp_start got=%b exp=0", txd); end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            rx_body(d);
            total++; if (d !== 8'h21 + 8'(k)) begin bad++; $display("FAIL pp_char k=%0d got=%02h exp=%02h", k, d, 8'h21 + 8'(k)); end
        end
        tick();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL pp_busy_end got=%b exp=0", tx_busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        bus_write(2'd1, 8'h00);
        bus_write(2'd0, 8'h00);
        bus_write(2'd0, 8'h5A);
        repeat (5) tick();
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL rm_bit3 got=%b exp=0", txd); end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL rm_busy_pre got=%b exp=1", tx_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rm_txd got=%b exp=1", txd); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", tx_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", fifo_count); end
        total++; if (tbr !== 1'b1) begin bad++; $display("FAIL rm_tbr got=%b exp=1", tbr); end
        bus_write(2'd0, 8'h3C);
        tick();
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL rm_new_start got=%b exp=0", txd); end
        rx_body(d);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL rm_new_char got=%02h exp=3c", d); end
        tick();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rm_busy_end got=%b exp=0", tx_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rm_count_end got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
